time_set_ctrl: RTL
==================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable clk cycles needed before a button level is accepted.
REQ-002 Parameter LOAD_CYCLES, default 12: clk cycles that a load strobe is held; must exceed one slow-tick period of the downstream clock.
REQ-003 clk  input  1  single system clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 btn_mode  input  1  raw push button: enter setting, or abort while setting.
REQ-006 btn_inc  input  1  raw push button: increment the selected field.
REQ-007 btn_set  input  1  raw push button: advance to the next field or commit.
REQ-008 sel_alarm  input  1  level: 0 = set time, 1 = set alarm; sampled on entry to setting.
REQ-009 cur_h1  input  2  current hour tens (BCD), fed back from the clock block.
REQ-010 cur_h0, cur_m1, cur_m0  input  4 each  current hour units, minute tens and minute units (BCD).
REQ-011 H_in1  output  2  hour tens (BCD) being edited or loaded.
REQ-012 H_in0, M_in1, M_in0  output  4 each  hour units, minute tens and minute units (BCD).
REQ-013 LD_time  output  1  time load strobe.
REQ-014 LD_alarm  output  1  alarm load strobe.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 field  output  2  00 idle, 01 hour, 10 minute, 11 commit.

Function
REQ-017 Each button SHALL pass through a 2-flop synchronizer, then a debounce counter; the debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles, and any mismatch-free cycle clears the counter.
REQ-018 A one-cycle press pulse SHALL be generated on each debounced 0->1 transition; the release edge generates nothing, and holding a button produces exactly one pulse.
REQ-019 The FSM SHALL have states IDLE, SET_HOUR, SET_MIN and COMMIT; all transitions are registered.
REQ-020 IDLE + mode pulse -> SET_HOUR; same edge: capture cur_h1/h0/m1/m0 into the edit registers and sel_alarm into the target flag.
REQ-021 SET_HOUR: inc pulse -> hour +1 in BCD (h0 9->0 with h1+1); 23 -> 00.
REQ-022 SET_HOUR: set pulse -> SET_MIN.
REQ-023 SET_MIN: inc pulse -> minute +1 in BCD; 59 -> 00; hour is not affected.
REQ-024 SET_MIN: set pulse -> COMMIT.
REQ-025 Mode pulse in SET_HOUR or SET_MIN -> IDLE with no strobe (abort); the edit registers keep their values.
REQ-026 Simultaneous pulses are resolved by priority: mode > set > inc; lower-priority pulses in the same cycle are discarded.
REQ-027 COMMIT: assert LD_alarm if the target flag = 1, else LD_time, for exactly LOAD_CYCLES cycles, then -> IDLE; never both strobes at once.
REQ-028 All button pulses are ignored in COMMIT and in IDLE, except mode in IDLE.
REQ-029 H_in*/M_in* SHALL drive the edit registers continuously; they are stable throughout COMMIT.
REQ-030 Edit registers SHALL only hold legal BCD: hours 00-23, minutes 00-59. If a captured feedback value is illegal, the first inc SHALL wrap the field to 00.
REQ-031 All outputs are registered.

Reset
REQ-032 reset low SHALL immediately force state IDLE, LD_time=0, LD_alarm=0, busy=0, field=00, edit registers 00:00, and clear the synchronizers, debounce counters and strobe counter.
REQ-033 Reset asserted mid-COMMIT SHALL terminate the strobe in the same instant; no load pulse resumes after reset release.
REQ-034 After reset release, a button already held high SHALL produce one press pulse once it has been debounced.

Verification
REQ-035 Bounce: btn_inc toggles every cycle for 10 cycles, then stays high in SET_HOUR with hour 09 -> exactly one increment, hour=10.
REQ-036 Wrap: cur=23:59; mode, inc -> H=00; set, inc -> M=00; set -> LD_time high exactly 12 cycles with outputs 00:00, busy drops afterwards.
REQ-037 Alarm path: sel_alarm=1, cur=15:30; mode, set, inc, set -> LD_alarm pulses 12 cycles with 15:31; LD_time stays 0.
REQ-038 Abort: mode, inc, inc, then mode -> IDLE; no strobe; busy=0.
REQ-039 Priority: set and inc debounced on the same cycle in SET_HOUR -> SET_MIN, hour unchanged.
REQ-040 Reset in COMMIT cycle 5 -> LD_time=0 immediately, state IDLE, outputs 00:00.

Source files
------------

// File: rtl/time_set_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : time_set_ctrl_if
// Brief    : Button, feedback and load-bus signals of the time/alarm setter.
// Revision : 1.0
// ============================================================================
interface time_set_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_set;
    logic       sel_alarm;
    logic [1:0] cur_h1;
    logic [3:0] cur_h0;
    logic [3:0] cur_m1;
    logic [3:0] cur_m0;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    logic       busy;
    logic [1:0] field;

    modport master (
        output btn_mode, btn_inc, btn_set, sel_alarm,
        output cur_h1, cur_h0, cur_m1, cur_m0,
        input  H_in1, H_in0, M_in1, M_in0,
        input  LD_time, LD_alarm, busy, field
    );

    modport slave (
        input  btn_mode, btn_inc, btn_set, sel_alarm,
        input  cur_h1, cur_h0, cur_m1, cur_m0,
        output H_in1, H_in0, M_in1, M_in0,
        output LD_time, LD_alarm, busy, field
    );
endinterface
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : time_set_ctrl
// Brief    : Debounced three-button editor for time/alarm with timed load strobe.
// Revision : 1.0
// ============================================================================
module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOAD_CYCLES     = 12
) (
    input  logic            clk,
    input  logic            reset,
    time_set_ctrl_if.slave  bus
);

    localparam int c_DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_LD_W  = $clog2(LOAD_CYCLES + 1);
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_LD_W-1:0]  c_LD_LAST  = c_LD_W'(LOAD_CYCLES - 1);

    // State encoding doubles as the field output code.
    localparam logic [1:0] c_IDLE     = 2'b00;
    localparam logic [1:0] c_SET_HOUR = 2'b01;
    localparam logic [1:0] c_SET_MIN  = 2'b10;
    localparam logic [1:0] c_COMMIT   = 2'b11;

    logic [2:0] w_btn_raw;
    logic [2:0] w_press;
    logic       w_mode;
    logic       w_inc;
    logic       w_set;

    assign w_btn_raw = {bus.btn_set, bus.btn_inc, bus.btn_mode};
    assign w_mode    = w_press[0];
    assign w_inc     = w_press[1];
    assign w_set     = w_press[2];

    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        logic [1:0]         sync_q, sync_d;
        logic               level_q, level_d;
        logic               prev_q, prev_d;
        logic [c_DEB_W-1:0] cnt_q, cnt_d;

        always_comb begin
            sync_d  = {sync_q[0], w_btn_raw[gi]};
            prev_d  = level_q;
            level_d = level_q;
            cnt_d   = '0;
            if (sync_q[1] != level_q) begin
                if (cnt_q == c_DEB_LAST) begin
                    level_d = sync_q[1];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_q  <= '0;
                level_q <= 1'b0;
                prev_q  <= 1'b0;
                cnt_q   <= '0;
            end else begin
                sync_q  <= sync_d;
                level_q <= level_d;
                prev_q  <= prev_d;
                cnt_q   <= cnt_d;
            end
        end

        assign w_press[gi] = level_q & ~prev_q;
    end

    logic [1:0]        state_q, state_d;
    logic [1:0]        h1_q, h1_d;
    logic [3:0]        h0_q, h0_d;
    logic [3:0]        m1_q, m1_d;
    logic [3:0]        m0_q, m0_d;
    logic              target_q, target_d;
    logic [c_LD_W-1:0] ld_cnt_q, ld_cnt_d;
    logic              busy_q, busy_d;
    logic              ld_time_q, ld_time_d;
    logic              ld_alarm_q, ld_alarm_d;

    // Out-of-range captured values fall into the wrap case so one inc cleans them up.
    logic w_hour_wrap;
    logic w_min_wrap;
    assign w_hour_wrap = !((h1_q < 2'd2 && h0_q <= 4'd9) || (h1_q == 2'd2 && h0_q <= 4'd3))
                       || (h1_q == 2'd2 && h0_q == 4'd3);
    assign w_min_wrap  = (m1_q > 4'd5) || (m0_q > 4'd9) || (m1_q == 4'd5 && m0_q == 4'd9);

    always_comb begin
        state_d  = state_q;
        h1_d     = h1_q;
        h0_d     = h0_q;
        m1_d     = m1_q;
        m0_d     = m0_q;
        target_d = target_q;
        ld_cnt_d = ld_cnt_q;
        case (state_q)
            c_IDLE: begin
                if (w_mode) begin
                    state_d  = c_SET_HOUR;
                    h1_d     = bus.cur_h1;
                    h0_d     = bus.cur_h0;
                    m1_d     = bus.cur_m1;
                    m0_d     = bus.cur_m0;
                    target_d = bus.sel_alarm;
                end
            end
            c_SET_HOUR: begin
                if (w_mode) begin
                    state_d = c_IDLE;
                end else if (w_set) begin
                    state_d = c_SET_MIN;
                end else if (w_inc) begin
                    if (w_hour_wrap) begin
                        h1_d = 2'd0;
                        h0_d = 4'd0;
                    end else if (h0_q == 4'd9) begin
                        h1_d = h1_q + 2'd1;
                        h0_d = 4'd0;
                    end else begin
                        h0_d = h0_q + 4'd1;
                    end
                end
            end
            c_SET_MIN: begin
                if (w_mode) begin
                    state_d = c_IDLE;
                end else if (w_set) begin
                    state_d  = c_COMMIT;
                    ld_cnt_d = '0;
                end else if (w_inc) begin
                    if (w_min_wrap) begin
                        m1_d = 4'd0;
                        m0_d = 4'd0;
                    end else if (m0_q == 4'd9) begin
                        m1_d = m1_q + 4'd1;
                        m0_d = 4'd0;
                    end else begin
                        m0_d = m0_q + 4'd1;
                    end
                end
            end
            c_COMMIT: begin
                if (ld_cnt_q == c_LD_LAST) begin
                    state_d  = c_IDLE;
                    ld_cnt_d = '0;
                end else begin
                    ld_cnt_d = ld_cnt_q + 1'b1;
                end
            end
            default: state_d = c_IDLE;
        endcase

        busy_d     = (state_d != c_IDLE);
        ld_time_d  = (state_d == c_COMMIT) && !target_d;
        ld_alarm_d = (state_d == c_COMMIT) &&  target_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= c_IDLE;
            h1_q       <= 2'd0;
            h0_q       <= 4'd0;
            m1_q       <= 4'd0;
            m0_q       <= 4'd0;
            target_q   <= 1'b0;
            ld_cnt_q   <= '0;
            busy_q     <= 1'b0;
            ld_time_q  <= 1'b0;
            ld_alarm_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            h1_q       <= h1_d;
            h0_q       <= h0_d;
            m1_q       <= m1_d;
            m0_q       <= m0_d;
            target_q   <= target_d;
            ld_cnt_q   <= ld_cnt_d;
            busy_q     <= busy_d;
            ld_time_q  <= ld_time_d;
            ld_alarm_q <= ld_alarm_d;
        end
    end

    assign bus.H_in1    = h1_q;
    assign bus.H_in0    = h0_q;
    assign bus.M_in1    = m1_q;
    assign bus.M_in0    = m0_q;
    assign bus.LD_time  = ld_time_q;
    assign bus.LD_alarm = ld_alarm_q;
    assign bus.busy     = busy_q;
    assign bus.field    = state_q;

endmodule
`default_nettype wire
